// File: rtl/axis_stream_arbiter_pkg.sv
// rtl/axis_stream_arbiter_pkg.sv - shared types, widths and helpers for the transmit arbiter
package axis_stream_arbiter_pkg;

   // Arbiter states: waiting for a request, forwarding a packet, closing a stalled packet
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_e;

   // Beat geometry shared with the AXIS data transmitter
   localparam int AXIS_DATA_WIDTH = 256;
   localparam int AXIS_KEEP_WIDTH = 32;

   // Ceiling log2, never narrower than one bit so single-entry ranges still get a vector
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered skid buffer for a valid/ready stream
module axis_skid_buffer
   import axis_stream_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_rdy,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_rdy
);

   logic                  out_vld_q,  out_vld_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  skid_vld_q,  skid_vld_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                  skid_last_q, skid_last_d;
   logic                  in_rdy_q,    in_rdy_d;
   logic                  in_accept;

   assign in_rdy    = in_rdy_q;
   assign out_vld   = out_vld_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign in_accept = in_vld & in_rdy_q;

   // Output stage refills from the skid entry first, then straight from the input;
   // a beat arriving while the output is stalled parks in the skid entry
   always_comb begin
      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      if (!out_vld_q || out_rdy) begin
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = skid_data_q;
            out_last_d = skid_last_q;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = in_accept;
            if (in_accept) begin
               out_data_d = in_data;
               out_last_d = in_last;
            end
         end
      end else if (in_accept) begin
         skid_vld_d  = 1'b1;
         skid_data_d = in_data;
         skid_last_d = in_last;
      end
      // Ready is a flop: it only drops once both entries hold a beat
      in_rdy_d = !skid_vld_d;
   end

   // Buffer registers; reset discards any held beats
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
         in_rdy_q    <= 1'b0;
      end else begin
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
         in_rdy_q    <= in_rdy_d;
      end
   end

endmodule

// File: rtl/axis_stream_arbiter.sv
// rtl/axis_stream_arbiter.sv - round-robin packet arbiter with stall watchdog onto one transmit stream
module axis_stream_arbiter
   import axis_stream_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH     = AXIS_DATA_WIDTH,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_vld,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_rdy,
   output logic                          transmit_vld,
   output logic [DATA_WIDTH-1:0]         transmit_data,
   output logic                          transmit_last,
   input  logic                          transmit_rdy,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          pkt_cnt,
   output logic [15:0]                   abort_cnt
);

   localparam int IDX_W  = clog2(NUM_REQ);
   localparam int IDLE_W = clog2(TIMEOUT_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

   arb_state_e           state_q,     state_d;
   logic [NUM_REQ-1:0]   grant_q,     grant_d;
   logic [IDX_W-1:0]     gidx_q,      gidx_d;
   logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
   logic [IDLE_W-1:0]    idle_cnt_q,  idle_cnt_d;
   logic [CNT_WIDTH-1:0] pkt_cnt_q,   pkt_cnt_d;
   logic [15:0]          abort_cnt_q, abort_cnt_d;

   logic                  arb_found;
   logic [IDX_W-1:0]      arb_idx;
   logic [NUM_REQ-1:0]    arb_onehot;
   logic                  g_vld;
   logic                  g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic [IDX_W-1:0]      next_ptr;

   logic                  sk_in_vld;
   logic [DATA_WIDTH-1:0] sk_in_data;
   logic                  sk_in_last;
   logic                  sk_in_rdy;

   assign grant     = grant_q;
   assign busy      = (state_q != ST_IDLE);
   assign pkt_cnt   = pkt_cnt_q;
   assign abort_cnt = abort_cnt_q;
   assign next_ptr  = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

   // Round-robin pick: first request at or above the pointer, else wrap to the lowest
   always_comb begin
      arb_found  = 1'b0;
      arb_idx    = '0;
      arb_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!arb_found && req_vld[i] && (IDX_W'(i) >= rr_ptr_q)) begin
            arb_found     = 1'b1;
            arb_idx       = IDX_W'(i);
            arb_onehot[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!arb_found && req_vld[i]) begin
            arb_found     = 1'b1;
            arb_idx       = IDX_W'(i);
            arb_onehot[i] = 1'b1;
         end
      end
   end

   // Select the granted requester's beat
   always_comb begin
      g_vld  = 1'b0;
      g_last = 1'b0;
      g_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx_q == IDX_W'(i)) begin
            g_vld  = req_vld[i];
            g_last = req_last[i];
            g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state, skid feed and per-requester ready
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      rr_ptr_d    = rr_ptr_q;
      idle_cnt_d  = idle_cnt_q;
      pkt_cnt_d   = pkt_cnt_q;
      abort_cnt_d = abort_cnt_q;
      req_rdy     = '0;
      sk_in_vld   = 1'b0;
      sk_in_data  = '0;
      sk_in_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               state_d    = ST_BUSY;
               gidx_d     = arb_idx;
               grant_d    = arb_onehot;
               idle_cnt_d = '0;
            end
         end
         ST_BUSY: begin
            sk_in_vld  = g_vld;
            sk_in_data = g_data;
            sk_in_last = g_last;
            req_rdy    = grant_q & {NUM_REQ{sk_in_rdy}};
            if (g_vld && sk_in_rdy) begin
               // An accepted last beat closes the packet even on the timeout cycle
               idle_cnt_d = '0;
               if (g_last) begin
                  state_d   = ST_IDLE;
                  grant_d   = '0;
                  rr_ptr_d  = next_ptr;
                  pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
               end
            end else if (!g_vld) begin
               // Only a silent source counts toward the timeout, not backpressure
               if (idle_cnt_q == IDLE_MAX) begin
                  state_d = ST_ABORT;
               end else begin
                  idle_cnt_d = idle_cnt_q + IDLE_W'(1);
               end
            end
         end
         ST_ABORT: begin
            // Terminate the open packet with an all-zero last beat
            sk_in_vld  = 1'b1;
            sk_in_last = 1'b1;
            if (sk_in_rdy) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               rr_ptr_d = next_ptr;
               if (abort_cnt_q != 16'hFFFF) begin
                  abort_cnt_d = abort_cnt_q + 16'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         rr_ptr_q    <= '0;
         idle_cnt_q  <= '0;
         pkt_cnt_q   <= '0;
         abort_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         rr_ptr_q    <= rr_ptr_d;
         idle_cnt_q  <= idle_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   axis_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (sk_in_vld),
      .in_data  (sk_in_data),
      .in_last  (sk_in_last),
      .in_rdy   (sk_in_rdy),
      .out_vld  (transmit_vld),
      .out_data (transmit_data),
      .out_last (transmit_last),
      .out_rdy  (transmit_rdy)
   );

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// tb/tb_axis_stream_arbiter.sv - directed self-checking bench for the transmit arbiter
module tb_axis_stream_arbiter;

   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic [1:0]    req_vld;
   logic [31:0]   d0, d1;
   logic [63:0]   req_data;
   logic [1:0]    req_last;
   logic [1:0]    req_rdy;
   logic          transmit_vld;
   logic [31:0]   transmit_data;
   logic          transmit_last;
   logic          transmit_rdy;
   logic [1:0]    grant;
   logic          busy;
   logic [31:0]   pkt_cnt;
   logic [15:0]   abort_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rst;
      logic [1:0]  vld;
      logic [1:0]  last;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        trdy;
      logic [1:0]  grant;
      logic [1:0]  rdy;
      logic        busy;
      logic        tvld;
      logic [31:0] tdata;
      logic        tlast;
      logic [31:0] pkt;
   } vec_t;

   vec_t        vecs[$];
   logic [32:0] mon_q[$];

   assign req_data = {d1, d0};

   axis_stream_arbiter #(
      .DATA_WIDTH     (DW),
      .NUM_REQ        (2),
      .TIMEOUT_CYCLES (16),
      .CNT_WIDTH      (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_vld       (req_vld),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_rdy       (req_rdy),
      .transmit_vld  (transmit_vld),
      .transmit_data (transmit_data),
      .transmit_last (transmit_last),
      .transmit_rdy  (transmit_rdy),
      .grant         (grant),
      .busy          (busy),
      .pkt_cnt       (pkt_cnt),
      .abort_cnt     (abort_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every beat the transmitter accepts
   always @(negedge clk) begin
      #2;
      if (transmit_vld && transmit_rdy) mon_q.push_back({transmit_last, transmit_data});
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] v, input logic [1:0] l,
                      input logic [31:0] a, input logic [31:0] b, input logic tr,
                      input logic [1:0] g, input logic [1:0] rd, input logic bs,
                      input logic tv, input logic [31:0] td, input logic tl, input logic [31:0] pk);
      vec_t e;
      e.rst = r; e.vld = v; e.last = l; e.d0 = a; e.d1 = b; e.trdy = tr;
      e.grant = g; e.rdy = rd; e.busy = bs; e.tvld = tv; e.tdata = td; e.tlast = tl; e.pkt = pk;
      vecs.push_back(e);
   endtask

   // Hold a beat on one source until it is accepted (bounded)
   task automatic drive_until_acc(input bit src, input logic [31:0] data, input logic last);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      if (src) d1 = data; else d0 = data;
      req_last[src] = last;
      req_vld[src]  = 1'b1;
      while (!acc && n < 50) begin
         #1;
         acc = req_rdy[src];
         @(negedge clk);
         n++;
      end
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL accept_wait: source %0d beat %0h got no ready want ready", src, data);
      end
   endtask

   initial begin
      logic [31:0] td_m;
      logic        tl_m;
      int          sidx, got, c;
      logic        stalled_prev, sacc;
      logic [31:0] prev_data;
      logic [3:0]  pat;

      // single source, 4 beats
      add(0, 2'b01, 2'b00, 32'h1, 32'h0, 1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 0);
      add(0, 2'b01, 2'b00, 32'h1, 32'h0, 1, 2'b01, 2'b01, 1, 0, 32'h0, 0, 0);
      add(0, 2'b01, 2'b00, 32'h2, 32'h0, 1, 2'b01, 2'b01, 1, 1, 32'h1, 0, 0);
      add(0, 2'b01, 2'b00, 32'h3, 32'h0, 1, 2'b01, 2'b01, 1, 1, 32'h2, 0, 0);
      add(0, 2'b01, 2'b01, 32'h4, 32'h0, 1, 2'b01, 2'b01, 1, 1, 32'h3, 0, 0);
      add(0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 2'b00, 0, 1, 32'h4, 1, 1);
      add(0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 1);
      // both request with pointer at 1: req1 first
      add(0, 2'b11, 2'b00, 32'h31, 32'h41, 1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 1);
      add(0, 2'b11, 2'b00, 32'h31, 32'h41, 1, 2'b10, 2'b10, 1, 0, 32'h0, 0, 1);
      add(0, 2'b11, 2'b10, 32'h31, 32'h42, 1, 2'b10, 2'b10, 1, 1, 32'h41, 0, 1);
      add(0, 2'b01, 2'b00, 32'h31, 32'h0, 1, 2'b00, 2'b00, 0, 1, 32'h42, 1, 2);
      add(0, 2'b01, 2'b00, 32'h31, 32'h0, 1, 2'b01, 2'b01, 1, 0, 32'h0, 0, 2);
      add(0, 2'b01, 2'b01, 32'h32, 32'h0, 1, 2'b01, 2'b01, 1, 1, 32'h31, 0, 2);
      add(0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 2'b00, 0, 1, 32'h32, 1, 3);
      add(0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 3);
      // reset, then contention from reset: req0 first, no interleave
      add(1, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 0);
      add(0, 2'b11, 2'b00, 32'h11, 32'h21, 1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 0);
      add(0, 2'b11, 2'b00, 32'h11, 32'h21, 1, 2'b01, 2'b01, 1, 0, 32'h0, 0, 0);
      add(0, 2'b11, 2'b00, 32'h12, 32'h21, 1, 2'b01, 2'b01, 1, 1, 32'h11, 0, 0);
      add(0, 2'b11, 2'b01, 32'h13, 32'h21, 1, 2'b01, 2'b01, 1, 1, 32'h12, 0, 0);
      add(0, 2'b10, 2'b00, 32'h0, 32'h21, 1, 2'b00, 2'b00, 0, 1, 32'h13, 1, 1);
      add(0, 2'b10, 2'b00, 32'h0, 32'h21, 1, 2'b10, 2'b10, 1, 0, 32'h0, 0, 1);
      add(0, 2'b10, 2'b00, 32'h0, 32'h22, 1, 2'b10, 2'b10, 1, 1, 32'h21, 0, 1);
      add(0, 2'b10, 2'b10, 32'h0, 32'h23, 1, 2'b10, 2'b10, 1, 1, 32'h22, 0, 1);
      add(0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 2'b00, 0, 1, 32'h23, 1, 2);
      add(0, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 2'b00, 0, 0, 32'h0, 0, 2);

      rst = 1'b1; req_vld = '0; req_last = '0; d0 = '0; d1 = '0; transmit_rdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_state", 128'({grant, req_rdy, busy, transmit_vld, transmit_data, transmit_last, pkt_cnt, abort_cnt}), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         rst = vecs[i].rst; req_vld = vecs[i].vld; req_last = vecs[i].last;
         d0 = vecs[i].d0; d1 = vecs[i].d1; transmit_rdy = vecs[i].trdy;
         #1;
         td_m = (vecs[i].tvld || vecs[i].rst) ? transmit_data : 32'h0;
         tl_m = (vecs[i].tvld || vecs[i].rst) ? transmit_last : 1'b0;
         chk($sformatf("vec%0d", i),
             128'({grant, req_rdy, busy, transmit_vld, td_m, tl_m, pkt_cnt}),
             128'({vecs[i].grant, vecs[i].rdy, vecs[i].busy, vecs[i].tvld, vecs[i].tdata, vecs[i].tlast, vecs[i].pkt}));
         @(negedge clk);
      end

      // backpressure: 8-beat packet, ready pattern 1,0,0,1
      pat = 4'b1001;
      sidx = 0; got = 0; c = 0; stalled_prev = 1'b0; prev_data = '0;
      while (got < 8 && c < 80) begin
         transmit_rdy = pat[3 - (c % 4)];
         req_vld[0]   = (sidx < 8);
         req_last[0]  = (sidx == 7);
         d0           = 32'h51 + 32'(sidx);
         #1;
         if (stalled_prev) chk("bp_stable", 128'({transmit_vld, transmit_data}), 128'({1'b1, prev_data}));
         sacc = req_vld[0] & req_rdy[0];
         if (transmit_vld && transmit_rdy) begin
            chk($sformatf("bp_beat%0d", got), 128'({transmit_last, transmit_data}), 128'({(got == 7), 32'h51 + 32'(got)}));
            got++;
         end
         stalled_prev = transmit_vld & ~transmit_rdy;
         prev_data    = transmit_data;
         @(negedge clk);
         if (sacc) sidx++;
         c++;
      end
      req_vld = '0; transmit_rdy = 1'b1;
      chk("bp_all_delivered", 128'(got), 128'(8));
      repeat (2) @(negedge clk);
      chk("bp_counts", 128'({pkt_cnt, abort_cnt}), 128'({32'd3, 16'd0}));

      // watchdog: two beats then silence
      drive_until_acc(0, 32'h61, 1'b0);
      drive_until_acc(0, 32'h62, 1'b0);
      req_vld[0] = 1'b0;
      repeat (16) @(negedge clk);
      #1;
      chk("wd_in_abort", 128'({busy, transmit_vld}), 128'({1'b1, 1'b0}));
      @(negedge clk);
      req_vld = 2'b11; req_last = 2'b11; d0 = 32'h63; d1 = 32'h71;
      #1;
      chk("wd_abort_beat", 128'({transmit_vld, transmit_last, transmit_data}), 128'({1'b1, 1'b1, 32'h0}));
      chk("wd_counts", 128'({abort_cnt, pkt_cnt}), 128'({16'd1, 32'd3}));
      chk("wd_released", 128'({busy, grant}), 128'(0));
      @(negedge clk);
      #1;
      chk("wd_next_grant", 128'(grant), 128'(2'b10));
      drive_until_acc(1, 32'h71, 1'b1);
      req_vld[1] = 1'b0;
      drive_until_acc(0, 32'h63, 1'b1);
      req_vld[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("wd_after_pkts", 128'(pkt_cnt), 128'(32'd5));

      // timeout race: last beat lands on the final idle-count cycle
      mon_q.delete();
      drive_until_acc(0, 32'h81, 1'b0);
      req_vld[0] = 1'b0;
      repeat (15) @(negedge clk);
      drive_until_acc(0, 32'h82, 1'b1);
      req_vld[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("race_beats", 128'(mon_q.size()), 128'(2));
      if (mon_q.size() == 2) begin
         chk("race_beat0", 128'(mon_q[0]), 128'({1'b0, 32'h81}));
         chk("race_beat1", 128'(mon_q[1]), 128'({1'b1, 32'h82}));
      end
      chk("race_counts", 128'({abort_cnt, pkt_cnt, busy}), 128'({16'd1, 32'd6, 1'b0}));

      // reset in the middle of a 6-beat packet
      drive_until_acc(0, 32'h91, 1'b0);
      drive_until_acc(0, 32'h92, 1'b0);
      d0 = 32'h93;
      rst = 1'b1;
      #1;
      chk("midrst_outputs", 128'({grant, req_rdy, busy, transmit_vld, transmit_data, transmit_last, pkt_cnt, abort_cnt}), 128'(0));
      req_vld = '0;
      @(negedge clk);
      rst = 1'b0;
      mon_q.delete();
      drive_until_acc(1, 32'hA1, 1'b0);
      drive_until_acc(1, 32'hA2, 1'b1);
      req_vld = '0;
      repeat (3) @(negedge clk);
      chk("midrst_beats", 128'(mon_q.size()), 128'(2));
      if (mon_q.size() == 2) begin
         chk("midrst_beat0", 128'(mon_q[0]), 128'({1'b0, 32'hA1}));
         chk("midrst_beat1", 128'(mon_q[1]), 128'({1'b1, 32'hA2}));
      end
      chk("midrst_counts", 128'({pkt_cnt, abort_cnt}), 128'({32'd1, 16'd0}));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
